// File: rtl/mem_access_if.sv
// Data-memory bus between the memory-access stage and the data memory.
//   dmem_req   : access request, held until dmem_ack
//   dmem_we    : 1 = write, 0 = read
//   dmem_adr   : word address (byte address [31:2])
//   dmem_be    : byte enables
//   dmem_wdata : write data, lane-replicated for sub-word stores
//   dmem_ack   : access complete; dmem_rdata valid in the same cycle
//   dmem_rdata : read word
interface mem_access_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [29:0] dmem_adr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_adr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_adr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage. Issues loads/stores on the data-memory bus,
// stalls the upstream stage until the access completes, and registers the
// writeback result. Misaligned/illegal accesses and bus timeouts raise a
// one-cycle exception pulse instead of writing back.
//   clk, rst          : clock, synchronous active-high reset
//   cmd_ld_ma/st_ma   : load / store command (both high = store)
//   wbk_rd_reg_ma     : instruction writes rd
//   rd_adr_ma         : destination register
//   rd_data_ma        : effective address for ld/st, else writeback value
//   st_data_ma        : store source data
//   ldst_code_ma      : funct3 access size/signedness
//   dmem              : data-memory bus (master side)
//   stall_ma          : upstream must hold its inputs
//   *_wb              : registered writeback
//   ma_exception      : one-cycle exception pulse with code and address
module mem_access (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_ld_ma,
    input  logic         cmd_st_ma,
    input  logic         wbk_rd_reg_ma,
    input  logic [4:0]   rd_adr_ma,
    input  logic [31:0]  rd_data_ma,
    input  logic [31:0]  st_data_ma,
    input  logic [2:0]   ldst_code_ma,
    mem_access_if.master dmem,
    output logic         stall_ma,
    output logic         wbk_rd_reg_wb,
    output logic [4:0]   rd_adr_wb,
    output logic [31:0]  rd_data_wb,
    output logic         ma_exception,
    output logic [3:0]   ma_exc_code,
    output logic [31:0]  ma_exc_adr
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [4:0]  rd_q, rd_d;
    logic        wbk_q, wbk_d;
    logic [2:0]  code_q, code_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        wb_vld_q, wb_vld_d;
    logic [4:0]  wb_adr_q, wb_adr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        exc_q, exc_d;
    logic [3:0]  exc_code_q, exc_code_d;
    logic [31:0] exc_adr_q, exc_adr_d;

    logic        is_st, is_ld, illegal, misaligned;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] rdata_sh, load_data;

    // A simultaneous load+store command is treated as a store.
    assign is_st = cmd_st_ma;
    assign is_ld = cmd_ld_ma & ~cmd_st_ma;

    assign illegal = is_st ? (ldst_code_ma[2] | (ldst_code_ma[1] & ldst_code_ma[0]))
                           : ((ldst_code_ma == 3'b011) || (ldst_code_ma[2:1] == 2'b11));

    assign misaligned = ((ldst_code_ma[1:0] == 2'b01) && rd_data_ma[0]) ||
                        ((ldst_code_ma[1:0] == 2'b10) && (rd_data_ma[1:0] != 2'b00));

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = st_data_ma;
        case (ldst_code_ma[1:0])
            2'b00: begin
                be_new    = 4'b0001 << rd_data_ma[1:0];
                wdata_new = {4{st_data_ma[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << rd_data_ma[1:0];
                wdata_new = {2{st_data_ma[15:0]}};
            end
            default: ;
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend per access code.
    always_comb begin
        rdata_sh  = dmem.dmem_rdata >> {adr_q[1:0], 3'b000};
        load_data = dmem.dmem_rdata;
        case (code_q)
            3'b000:  load_data = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            3'b001:  load_data = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            3'b100:  load_data = {24'h000000, rdata_sh[7:0]};
            3'b101:  load_data = {16'h0000, rdata_sh[15:0]};
            default: load_data = dmem.dmem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        rd_d       = rd_q;
        wbk_d      = wbk_q;
        code_d     = code_q;
        cnt_d      = cnt_q;
        wb_vld_d   = 1'b0;
        wb_adr_d   = wb_adr_q;
        wb_data_d  = wb_data_q;
        exc_d      = 1'b0;
        exc_code_d = exc_code_q;
        exc_adr_d  = exc_adr_q;
        stall_ma   = 1'b0;

        case (state_q)
            IDLE: begin
                if (is_ld || is_st) begin
                    if (illegal || misaligned) begin
                        exc_d      = 1'b1;
                        exc_code_d = is_st ? 4'd6 : 4'd4;
                        exc_adr_d  = rd_data_ma;
                    end else begin
                        adr_d    = rd_data_ma;
                        be_d     = be_new;
                        wdata_d  = wdata_new;
                        we_d     = is_st;
                        rd_d     = rd_adr_ma;
                        wbk_d    = wbk_rd_reg_ma;
                        code_d   = ldst_code_ma;
                        cnt_d    = '0;
                        state_d  = BUSY;
                        stall_ma = 1'b1;
                    end
                end else begin
                    wb_vld_d  = wbk_rd_reg_ma;
                    wb_adr_d  = rd_adr_ma;
                    wb_data_d = rd_data_ma;
                end
            end
            BUSY: begin
                // Ack takes priority over an expiring timeout counter.
                if (dmem.dmem_ack) begin
                    state_d = IDLE;
                    if (!we_q) begin
                        wb_vld_d  = wbk_q;
                        wb_adr_d  = rd_q;
                        wb_data_d = load_data;
                    end
                end else if (cnt_q == 8'hFF) begin
                    state_d    = IDLE;
                    exc_d      = 1'b1;
                    exc_code_d = we_q ? 4'd7 : 4'd5;
                    exc_adr_d  = adr_q;
                end else begin
                    cnt_d    = cnt_q + 8'd1;
                    stall_ma = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            adr_q      <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            rd_q       <= '0;
            wbk_q      <= 1'b0;
            code_q     <= '0;
            cnt_q      <= '0;
            wb_vld_q   <= 1'b0;
            wb_adr_q   <= '0;
            wb_data_q  <= '0;
            exc_q      <= 1'b0;
            exc_code_q <= '0;
            exc_adr_q  <= '0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            rd_q       <= rd_d;
            wbk_q      <= wbk_d;
            code_q     <= code_d;
            cnt_q      <= cnt_d;
            wb_vld_q   <= wb_vld_d;
            wb_adr_q   <= wb_adr_d;
            wb_data_q  <= wb_data_d;
            exc_q      <= exc_d;
            exc_code_q <= exc_code_d;
            exc_adr_q  <= exc_adr_d;
        end
    end

    assign dmem.dmem_req   = (state_q == BUSY);
    assign dmem.dmem_we    = (state_q == BUSY) & we_q;
    assign dmem.dmem_be    = (state_q == BUSY) ? be_q : '0;
    assign dmem.dmem_adr   = adr_q[31:2];
    assign dmem.dmem_wdata = wdata_q;

    assign wbk_rd_reg_wb = wb_vld_q;
    assign rd_adr_wb     = wb_adr_q;
    assign rd_data_wb    = wb_data_q;
    assign ma_exception  = exc_q;
    assign ma_exc_code   = exc_code_q;
    assign ma_exc_adr    = exc_adr_q;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_ld_ma, cmd_st_ma, wbk_rd_reg_ma;
    logic [4:0]  rd_adr_ma;
    logic [31:0] rd_data_ma, st_data_ma;
    logic [2:0]  ldst_code_ma;
    logic        stall_ma, wbk_rd_reg_wb, ma_exception;
    logic [4:0]  rd_adr_wb;
    logic [31:0] rd_data_wb, ma_exc_adr;
    logic [3:0]  ma_exc_code;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  adr;
        logic [31:0] data;
    } wb_t;

    wb_t sb_q[$];
    wb_t exp_wb;

    mem_access_if dmem_bus ();

    mem_access dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_ld_ma     (cmd_ld_ma),
        .cmd_st_ma     (cmd_st_ma),
        .wbk_rd_reg_ma (wbk_rd_reg_ma),
        .rd_adr_ma     (rd_adr_ma),
        .rd_data_ma    (rd_data_ma),
        .st_data_ma    (st_data_ma),
        .ldst_code_ma  (ldst_code_ma),
        .dmem          (dmem_bus),
        .stall_ma      (stall_ma),
        .wbk_rd_reg_wb (wbk_rd_reg_wb),
        .rd_adr_wb     (rd_adr_wb),
        .rd_data_wb    (rd_data_wb),
        .ma_exception  (ma_exception),
        .ma_exc_code   (ma_exc_code),
        .ma_exc_adr    (ma_exc_adr)
    );

    always #5 clk = ~clk;

    // Writeback scoreboard: every writeback must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && wbk_rd_reg_wb) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL wb_spurious: got rd %0d data %h, expected no writeback", rd_adr_wb, rd_data_wb);
            end else begin
                exp_wb = sb_q.pop_front();
                if (rd_adr_wb !== exp_wb.adr || rd_data_wb !== exp_wb.data) begin
                    errors++;
                    $display("FAIL wb_value: got rd %0d data %h, expected rd %0d data %h",
                             rd_adr_wb, rd_data_wb, exp_wb.adr, exp_wb.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cmd();
        cmd_ld_ma     = 1'b0;
        cmd_st_ma     = 1'b0;
        wbk_rd_reg_ma = 1'b0;
        rd_adr_ma     = '0;
        rd_data_ma    = '0;
        st_data_ma    = '0;
        ldst_code_ma  = '0;
    endtask

    task automatic push_wb(input logic [4:0] adr, input logic [31:0] data);
        wb_t e;
        e.adr  = adr;
        e.data = data;
        sb_q.push_back(e);
    endtask

    // Drives one legal access, acks it after 'waits' busy cycles, and reports
    // what the bus showed. Starts and ends one time unit after a rising edge.
    task automatic run_access(input logic ld, input logic st, input logic wbk,
                              input logic [2:0] code, input logic [31:0] adr,
                              input logic [31:0] sdata, input logic [4:0] rd,
                              input int unsigned waits, input logic [31:0] rdata,
                              output int unsigned req_cycles, output logic stall_first,
                              output logic stall_ack, output logic [29:0] bus_adr,
                              output logic [3:0] bus_be, output logic [31:0] bus_wdata,
                              output logic bus_we);
        cmd_ld_ma     = ld;
        cmd_st_ma     = st;
        wbk_rd_reg_ma = wbk;
        rd_adr_ma     = rd;
        rd_data_ma    = adr;
        st_data_ma    = sdata;
        ldst_code_ma  = code;
        req_cycles    = 0;
        @(negedge clk);
        stall_first = stall_ma;
        if (dmem_bus.dmem_req) req_cycles++;
        tick();
        for (int unsigned i = 0; i < waits; i++) begin
            @(negedge clk);
            if (dmem_bus.dmem_req) req_cycles++;
            tick();
        end
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = rdata;
        @(negedge clk);
        if (dmem_bus.dmem_req) req_cycles++;
        stall_ack = stall_ma;
        bus_adr   = dmem_bus.dmem_adr;
        bus_be    = dmem_bus.dmem_be;
        bus_wdata = dmem_bus.dmem_wdata;
        bus_we    = dmem_bus.dmem_we;
        tick();
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = 32'hDEAD_BEEF;
        clear_cmd();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_cmd();
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = '0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_be, dmem_bus.dmem_adr, dmem_bus.dmem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_bus: got req %b we %b be %h adr %h wdata %h, expected all zero",
                     dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_be, dmem_bus.dmem_adr, dmem_bus.dmem_wdata);
        end
        checks++;
        if ({stall_ma, wbk_rd_reg_wb, rd_adr_wb, rd_data_wb, ma_exception, ma_exc_code, ma_exc_adr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got stall %b wbk %b rd %0d data %h exc %b code %0d adr %h, expected all zero",
                     stall_ma, wbk_rd_reg_wb, rd_adr_wb, rd_data_wb, ma_exception, ma_exc_code, ma_exc_adr);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_load_word();
        int unsigned n;
        logic sf, sa, we;
        logic [29:0] ad;
        logic [3:0] be;
        logic [31:0] wd;
        push_wb(5'd5, 32'h1234_5678);
        run_access(1'b1, 1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 5'd5, 2, 32'h1234_5678, n, sf, sa, ad, be, wd, we);
        checks++;
        if (n !== 3) begin errors++; $display("FAIL lw_req_cycles: got %0d expected 3", n); end
        checks++;
        if (sf !== 1'b1 || sa !== 1'b0) begin errors++; $display("FAIL lw_stall: got issue %b ack %b expected 1 0", sf, sa); end
        checks++;
        if (ad !== 30'h40 || be !== 4'hF || we !== 1'b0) begin
            errors++;
            $display("FAIL lw_bus: got adr %h be %h we %b expected 40 f 0", ad, be, we);
        end
        @(negedge clk);
        checks++;
        if (wbk_rd_reg_wb !== 1'b1 || dmem_bus.dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL lw_complete: got wbk %b req %b expected 1 0", wbk_rd_reg_wb, dmem_bus.dmem_req);
        end
        tick();
    endtask

    task automatic test_load_lanes();
        int unsigned n;
        logic sf, sa, we;
        logic [29:0] ad;
        logic [3:0] be;
        logic [31:0] wd;
        push_wb(5'd7, 32'hFFFF_FF80);
        run_access(1'b1, 1'b0, 1'b1, 3'b000, 32'h203, 32'h0, 5'd7, 0, 32'h80AA_BBCC, n, sf, sa, ad, be, wd, we);
        checks++;
        if (be !== 4'b1000 || n !== 1) begin errors++; $display("FAIL lb_bus: got be %b req cycles %0d expected 1000 1", be, n); end
        push_wb(5'd8, 32'h0000_0080);
        run_access(1'b1, 1'b0, 1'b1, 3'b100, 32'h203, 32'h0, 5'd8, 1, 32'h80AA_BBCC, n, sf, sa, ad, be, wd, we);
        checks++;
        if (be !== 4'b1000) begin errors++; $display("FAIL lbu_be: got %b expected 1000", be); end
        push_wb(5'd9, 32'hFFFF_80AA);
        run_access(1'b1, 1'b0, 1'b1, 3'b001, 32'h202, 32'h0, 5'd9, 0, 32'h80AA_BBCC, n, sf, sa, ad, be, wd, we);
        checks++;
        if (be !== 4'b1100) begin errors++; $display("FAIL lh_be: got %b expected 1100", be); end
        push_wb(5'd10, 32'h0000_BBCC);
        run_access(1'b1, 1'b0, 1'b1, 3'b101, 32'h200, 32'h0, 5'd10, 0, 32'h80AA_BBCC, n, sf, sa, ad, be, wd, we);
        checks++;
        if (be !== 4'b0011 || ad !== 30'h80) begin errors++; $display("FAIL lhu_bus: got be %b adr %h expected 0011 80", be, ad); end
        push_wb(5'd11, 32'h0000_00AA);
        run_access(1'b1, 1'b0, 1'b1, 3'b100, 32'h202, 32'h0, 5'd11, 0, 32'h80AA_BBCC, n, sf, sa, ad, be, wd, we);
        checks++;
        if (be !== 4'b0100) begin errors++; $display("FAIL lbu2_be: got %b expected 0100", be); end
    endtask

    task automatic test_store();
        int unsigned n;
        logic sf, sa, we;
        logic [29:0] ad;
        logic [3:0] be;
        logic [31:0] wd;
        run_access(1'b0, 1'b1, 1'b0, 3'b001, 32'h302, 32'h0000_BEEF, 5'd1, 1, 32'h0, n, sf, sa, ad, be, wd, we);
        checks++;
        if (be !== 4'b1100 || wd !== 32'hBEEF_BEEF || we !== 1'b1 || ad !== 30'hC0) begin
            errors++;
            $display("FAIL sh_bus: got be %b wdata %h we %b adr %h expected 1100 beefbeef 1 c0", be, wd, we, ad);
        end
        run_access(1'b0, 1'b1, 1'b0, 3'b000, 32'h101, 32'h1234_565A, 5'd1, 0, 32'h0, n, sf, sa, ad, be, wd, we);
        checks++;
        if (be !== 4'b0010 || wd !== 32'h5A5A_5A5A || we !== 1'b1) begin
            errors++;
            $display("FAIL sb_bus: got be %b wdata %h we %b expected 0010 5a5a5a5a 1", be, wd, we);
        end
        run_access(1'b0, 1'b1, 1'b1, 3'b010, 32'h400, 32'hCAFE_F00D, 5'd2, 3, 32'h0, n, sf, sa, ad, be, wd, we);
        checks++;
        if (be !== 4'hF || wd !== 32'hCAFE_F00D || ad !== 30'h100 || n !== 4) begin
            errors++;
            $display("FAIL sw_bus: got be %h wdata %h adr %h req cycles %0d expected f cafef00d 100 4", be, wd, ad, n);
        end
        // Load and store together behave as a store; the wbk flag must not produce a writeback.
        run_access(1'b1, 1'b1, 1'b1, 3'b010, 32'h500, 32'h0000_0077, 5'd4, 0, 32'h1111_1111, n, sf, sa, ad, be, wd, we);
        checks++;
        if (we !== 1'b1 || wd !== 32'h0000_0077) begin
            errors++;
            $display("FAIL ldst_both: got we %b wdata %h expected 1 00000077", we, wd);
        end
    endtask

    task automatic test_exceptions();
        typedef struct packed {
            logic        ld;
            logic        st;
            logic [2:0]  code;
            logic [31:0] adr;
            logic [3:0]  exc;
        } exc_t;
        exc_t tbl[8];
        tbl[0] = '{1'b1, 1'b0, 3'b010, 32'h0000_0102, 4'd4};
        tbl[1] = '{1'b0, 1'b1, 3'b001, 32'h0000_0301, 4'd6};
        tbl[2] = '{1'b1, 1'b0, 3'b011, 32'h0000_0100, 4'd4};
        tbl[3] = '{1'b1, 1'b0, 3'b110, 32'h0000_0104, 4'd4};
        tbl[4] = '{1'b0, 1'b1, 3'b011, 32'h0000_0108, 4'd6};
        tbl[5] = '{1'b0, 1'b1, 3'b100, 32'h0000_010C, 4'd6};
        tbl[6] = '{1'b0, 1'b1, 3'b010, 32'h0000_0403, 4'd6};
        tbl[7] = '{1'b1, 1'b0, 3'b101, 32'h0000_0011, 4'd4};
        for (int unsigned i = 0; i < 8; i++) begin
            cmd_ld_ma     = tbl[i].ld;
            cmd_st_ma     = tbl[i].st;
            wbk_rd_reg_ma = tbl[i].ld;
            rd_adr_ma     = 5'd6;
            rd_data_ma    = tbl[i].adr;
            st_data_ma    = 32'h5555_5555;
            ldst_code_ma  = tbl[i].code;
            @(negedge clk);
            checks++;
            if (stall_ma !== 1'b0 || dmem_bus.dmem_req !== 1'b0) begin
                errors++;
                $display("FAIL exc%0d_issue: got stall %b req %b expected 0 0", i, stall_ma, dmem_bus.dmem_req);
            end
            tick();
            clear_cmd();
            @(negedge clk);
            checks++;
            if (ma_exception !== 1'b1 || ma_exc_code !== tbl[i].exc || ma_exc_adr !== tbl[i].adr || dmem_bus.dmem_req !== 1'b0) begin
                errors++;
                $display("FAIL exc%0d_pulse: got exc %b code %0d adr %h req %b expected 1 %0d %h 0",
                         i, ma_exception, ma_exc_code, ma_exc_adr, dmem_bus.dmem_req, tbl[i].exc, tbl[i].adr);
            end
            tick();
            @(negedge clk);
            checks++;
            if (ma_exception !== 1'b0) begin errors++; $display("FAIL exc%0d_width: got %b expected 0", i, ma_exception); end
            tick();
        end
    endtask

    task automatic test_timeout(input logic st);
        int unsigned n;
        logic last_stall;
        logic [3:0] exp_code;
        exp_code      = st ? 4'd7 : 4'd5;
        cmd_ld_ma     = ~st;
        cmd_st_ma     = st;
        wbk_rd_reg_ma = ~st;
        rd_adr_ma     = 5'd12;
        rd_data_ma    = 32'h0000_0600;
        st_data_ma    = 32'h0000_0011;
        ldst_code_ma  = 3'b010;
        n             = 0;
        last_stall    = 1'b1;
        tick();
        for (int unsigned i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!dmem_bus.dmem_req) break;
            n++;
            last_stall = stall_ma;
            tick();
            if (!last_stall) clear_cmd();
        end
        checks++;
        if (n !== 256) begin errors++; $display("FAIL timeout_req_cycles: got %0d expected 256", n); end
        checks++;
        if (last_stall !== 1'b0) begin errors++; $display("FAIL timeout_stall: got %b expected 0", last_stall); end
        checks++;
        if (ma_exception !== 1'b1 || ma_exc_code !== exp_code || ma_exc_adr !== 32'h600) begin
            errors++;
            $display("FAIL timeout_exc: got exc %b code %0d adr %h expected 1 %0d 00000600",
                     ma_exception, ma_exc_code, ma_exc_adr, exp_code);
        end
        clear_cmd();
        tick();
    endtask

    task automatic test_ack_at_limit();
        int unsigned n;
        logic sf, sa, we;
        logic [29:0] ad;
        logic [3:0] be;
        logic [31:0] wd;
        push_wb(5'd13, 32'hA5A5_0F0F);
        run_access(1'b1, 1'b0, 1'b1, 3'b010, 32'h700, 32'h0, 5'd13, 255, 32'hA5A5_0F0F, n, sf, sa, ad, be, wd, we);
        checks++;
        if (n !== 256 || sa !== 1'b0) begin errors++; $display("FAIL ack_limit_req: got cycles %0d stall %b expected 256 0", n, sa); end
        @(negedge clk);
        checks++;
        if (ma_exception !== 1'b0) begin errors++; $display("FAIL ack_limit_exc: got %b expected 0", ma_exception); end
        tick();
    endtask

    task automatic test_reset_busy();
        cmd_ld_ma     = 1'b1;
        wbk_rd_reg_ma = 1'b1;
        rd_adr_ma     = 5'd14;
        rd_data_ma    = 32'h100;
        ldst_code_ma  = 3'b010;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (dmem_bus.dmem_req !== 1'b1) begin errors++; $display("FAIL rstbusy_pre: got req %b expected 1", dmem_bus.dmem_req); end
        tick();
        rst = 1'b1;
        clear_cmd();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_be, dmem_bus.dmem_adr, dmem_bus.dmem_wdata, stall_ma} !== '0) begin
            errors++;
            $display("FAIL rstbusy_bus: got req %b we %b be %h adr %h wdata %h stall %b expected all zero",
                     dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_be, dmem_bus.dmem_adr, dmem_bus.dmem_wdata, stall_ma);
        end
        checks++;
        if ({wbk_rd_reg_wb, rd_adr_wb, rd_data_wb, ma_exception, ma_exc_code, ma_exc_adr} !== '0) begin
            errors++;
            $display("FAIL rstbusy_out: got wbk %b rd %0d data %h exc %b code %0d adr %h expected all zero",
                     wbk_rd_reg_wb, rd_adr_wb, rd_data_wb, ma_exception, ma_exc_code, ma_exc_adr);
        end
        tick();
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        checks++;
        if (dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL late_ack_req: got %b expected 0", dmem_bus.dmem_req); end
        tick();
        dmem_bus.dmem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (wbk_rd_reg_wb !== 1'b0) begin errors++; $display("FAIL late_ack_wb: got %b expected 0", wbk_rd_reg_wb); end
        tick();
        wbk_rd_reg_ma = 1'b1;
        rd_adr_ma     = 5'd3;
        rd_data_ma    = 32'h5;
        push_wb(5'd3, 32'h5);
        @(negedge clk);
        checks++;
        if (stall_ma !== 1'b0) begin errors++; $display("FAIL add_stall: got %b expected 0", stall_ma); end
        tick();
        clear_cmd();
        @(negedge clk);
        checks++;
        if (wbk_rd_reg_wb !== 1'b1) begin errors++; $display("FAIL add_wbk: got %b expected 1", wbk_rd_reg_wb); end
        tick();
    endtask

    task automatic test_back_to_back();
        int unsigned n;
        logic sf, sa, we;
        logic [29:0] ad;
        logic [3:0] be;
        logic [31:0] wd;
        logic [31:0] v;
        for (int unsigned i = 0; i < 5; i++) begin
            v             = $urandom;
            wbk_rd_reg_ma = (i != 3);
            rd_adr_ma     = 5'(i + 16);
            rd_data_ma    = v;
            if (i != 3) push_wb(5'(i + 16), v);
            @(negedge clk);
            checks++;
            if (stall_ma !== 1'b0 || dmem_bus.dmem_req !== 1'b0) begin
                errors++;
                $display("FAIL b2b%0d_stall: got stall %b req %b expected 0 0", i, stall_ma, dmem_bus.dmem_req);
            end
            tick();
        end
        push_wb(5'd20, 32'h0BAD_F00D);
        run_access(1'b1, 1'b0, 1'b1, 3'b010, 32'h104, 32'h0, 5'd20, 0, 32'h0BAD_F00D, n, sf, sa, ad, be, wd, we);
        checks++;
        if (n !== 1 || ad !== 30'h41) begin errors++; $display("FAIL b2b_lw: got cycles %0d adr %h expected 1 41", n, ad); end
        tick();
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_lanes();
        test_store();
        test_exceptions();
        test_timeout(1'b1);
        test_timeout(1'b0);
        test_ack_at_limit();
        test_reset_busy();
        test_back_to_back();
        tick();
        tick();
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL wb_missing: got %0d outstanding writebacks expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 cmd_ld_ma  in  1  load command from execution stage.
REQ-004 cmd_st_ma  in  1  store command from execution stage.
REQ-005 wbk_rd_reg_ma  in  1  instruction writes rd.
REQ-006 rd_adr_ma  in  5  destination register.
REQ-007 rd_data_ma  in  32  effective address for ld/st, otherwise result to write back.
REQ-008 st_data_ma  in  32  store source data, rs2.
REQ-009 ldst_code_ma  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 dmem_req  out  1  bus request, held until ack.
REQ-011 dmem_we  out  1  1 = write.
REQ-012 dmem_adr  out  30  word address [31:2].
REQ-013 dmem_be  out  4  byte enables.
REQ-014 dmem_wdata  out  32  write data, lane-replicated.
REQ-015 dmem_ack  in  1  access done; read data valid in the same cycle.
REQ-016 dmem_rdata  in  32  read word.
REQ-017 stall_ma  out  1  upstream holds all *_ma inputs while high.
REQ-018 wbk_rd_reg_wb / rd_adr_wb / rd_data_wb  out  1/5/32  registered writeback.
REQ-019 ma_exception  out  1  one-cycle exception pulse.
REQ-020 ma_exc_code / ma_exc_adr  out  4/32  cause, faulting address.

Function
REQ-021 FSM has two states: IDLE and BUSY; reset state is IDLE.
REQ-022 IDLE, (cmd_ld_ma|cmd_st_ma), access legal: latch address, be, wdata, we, rd, code; go to BUSY; stall_ma=1 this cycle.
REQ-023 BUSY: dmem_req=1 with latched fields; stall_ma = ~dmem_ack; on ack go to IDLE.
REQ-024 Load ack: rd_data_wb <= lane-selected dmem_rdata (B/H sign-extended, BU/HU zero-extended); wbk_rd_reg_wb <= latched wbk flag; both valid the next cycle.
REQ-025 Store ack: wbk_rd_reg_wb <= 0.
REQ-026 Non-ld/st in IDLE: wbk_rd_reg_wb, rd_adr_wb, rd_data_wb <= inputs; latency 1; stall_ma=0.
REQ-027 Cycles with no completion: wbk_rd_reg_wb <= 0.
REQ-028 Byte enables: B 0001<<adr[1:0]; H 0011<<adr[1:0]; W 1111.
REQ-029 Write data: SB byte x4; SH half x2; SW as-is.
REQ-030 Misaligned: H with adr[0]=1, W with adr[1:0]!=00.
REQ-031 Illegal code: load 011/110/111; store >=011.
REQ-032 Misaligned or illegal access: no bus request; stall_ma=0; ma_exception pulses next cycle; ma_exc_adr=address; code 4 load / 6 store; no writeback.
REQ-033 Timeout: 8-bit counter clears on BUSY entry and increments per BUSY cycle without ack.
REQ-034 Counter at 255 without ack: drop req; go to IDLE; ma_exception pulse; code 5 load / 7 store; no writeback; stall_ma=0 that cycle.
REQ-035 Ack and counter=255 in the same cycle: ack wins; normal completion.
REQ-036 cmd_ld_ma and cmd_st_ma both high: treat as store.
REQ-037 dmem_req never asserts in IDLE; outputs hold while BUSY.

Reset
REQ-038 rst in any state (including BUSY mid-access) forces IDLE next edge: dmem_req=0, dmem_we=0, dmem_be=0, dmem_adr=0, dmem_wdata=0, stall_ma=0, wbk_rd_reg_wb=0, rd_adr_wb=0, rd_data_wb=0, ma_exception=0, ma_exc_code=0, ma_exc_adr=0, counter=0.
REQ-039 A pending ack arriving after reset is ignored.

Verification
REQ-040 LW adr 0x100, ack after 2 wait cycles, rdata 0x12345678 -> req 3 cycles, dmem_adr 0x40, be 1111, rd_data_wb=0x12345678 one cycle after ack.
REQ-041 LB adr 0x203, rdata 0x80AABBCC -> be 1000, rd_data_wb=0xFFFFFF80; LBU same -> 0x00000080.
REQ-042 SH adr 0x302, st_data 0x0000BEEF -> be 1100, wdata 0xBEEFBEEF, we=1, no writeback.
REQ-043 LW adr 0x102 -> no dmem_req; ma_exception pulse, code 4, exc_adr 0x102.
REQ-044 SW with no ack -> req 256 cycles, then code 7, stall_ma low, IDLE.
REQ-045 rst during BUSY, then ADD result 0x5 rd 3 -> req drops; wbk_rd_reg_wb=1, rd_data_wb=5 one cycle after ADD.
